serial_alu: RTL and testbench
=============================

# serial_alu

Multi-cycle, parametrised ALU that processes a WIDTH-bit operation in SLICE-bit chunks, one chunk per clock, LSB first, with the carry held in a flop between chunks. It is the sequential successor to the single-bit ALU cell and supports AND, OR, ADD, SUB, SLT and NOR, with zero and overflow flags. It sits behind the datapath control with a start/busy/done handshake, for area-constrained configurations where a full-width ripple ALU is too large.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; K = WIDTH/SLICE cycles per operation.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- ALU_control  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- src1  in  WIDTH  operand A; captured on the accepting edge.
- src2  in  WIDTH  operand B; captured on the accepting edge.
- busy  out  1  operation in progress; start is ignored while high.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  WIDTH  registered result; holds until the next accepted start.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start=1. The edge latches src1, src2, the opcode and slice counter=0, and sets carry = 1 for SUB/SLT, 0 otherwise.
  - RUN: each edge processes slice[cnt] and advances cnt. Ainvert=1 for NOR. Binvert=1 for SUB, SLT and NOR. NOR is computed as AND of the inverted operands.
  - RUN→DONE on the edge that processes slice K-1.
  - DONE→IDLE on the next edge, or DONE→RUN if start=1 (back-to-back).
- Operands are shifted right by SLICE per edge. Slice results are shifted into the top of the result register.
- Carry out of slice i feeds the carry in of slice i+1 through a flop. The carry out of slice K-1 is discarded except for overflow.
- overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only.
- SLT: the final edge writes result = {WIDTH-1 zeros, less}, where less = MSB(A-B) XOR overflow(A-B).
- zero is registered with result on the final edge.
- An unknown opcode produces result = 0, zero = 1, overflow = 0, with normal latency.
- start while busy=1 is ignored, with no side effects.
- rst at any time, including mid-RUN, forces IDLE and aborts the operation.

## Timing
- Reset values: busy=0, done=0, result=0, zero=0, overflow=0, state IDLE, cnt=0, carry=0.
- If start is accepted at edge t0:
  - busy is high during cycles t0..tK.
  - done is high only in the cycle after tK.
  - result is valid in that same cycle and stays stable until the next acceptance.
- Latency is K edges from acceptance to done. Back-to-back throughput is one op per K+1 cycles.
- busy=0 in the DONE cycle, so start is accepted there.
- result is not cleared when a new op starts. Partial values are visible while busy=1 and must not be consumed.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: zero and overflow are computed as specified.
- SERIAL_ALU_FLAGS_EN undefined: zero and overflow are tied to 0 and the flag logic is removed. SLT still computes overflow internally for the less bit.

## Structure
- Package serial_alu_pkg holds:
  - the opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR);
  - the state enum (IDLE, RUN, DONE);
  - a function decoding opcode to {a_inv, b_inv, cin, sel[1:0]}.
- Sub-module alu_slice: a combinational SLICE-bit slice with inputs a, b, a_inv, b_inv, cin, sel and outputs res, cout, plus the MSB carry-in (used for overflow).
- Top level contains the FSM, counter, shift registers and flag logic.

## Test plan
- Reset then idle: all outputs 0 and busy=0; start with ADD 5+7 → done pulses exactly 8 cycles after acceptance (WIDTH=32, SLICE=4), result=12, zero=0, overflow=0.
- SUB 0x7FFFFFFF-0xFFFFFFFF → result=0x80000000, overflow=1; ADD 0xFFFFFFFF+1 → result=0, zero=1, overflow=0.
- SLT -3 vs 2 → result=1; SLT 0x7FFFFFFF vs 0x80000000 → result=0 (overflow-corrected); AND/OR/NOR of 0xF0F0F0F0 and 0x0FF00FF0 → 0x00F000F0, 0xFFF0FFF0, 0x000F000F.
- start pulsed at every cycle while busy → exactly one operation, done once; start held in the DONE cycle → second op accepted with no idle gap.
- rst asserted mid-RUN (cnt=3) → next cycle IDLE with all outputs 0, and a new op completes correctly.
- Undefined SERIAL_ALU_FLAGS_EN with ADD 0xFFFFFFFF+1 → zero=0, overflow=0, result=0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared opcodes, FSM states and opcode decode for the serial ALU.
package serial_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Slice output select
  localparam logic [1:0] SEL_AND  = 2'd0;
  localparam logic [1:0] SEL_OR   = 2'd1;
  localparam logic [1:0] SEL_SUM  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic       cin;
    logic [1:0] sel;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c.a_inv = 1'b0;
    c.b_inv = 1'b0;
    c.cin   = 1'b0;
    c.sel   = SEL_ZERO;
    case (op)
      OP_AND: c.sel = SEL_AND;
      OP_OR:  c.sel = SEL_OR;
      OP_ADD: c.sel = SEL_SUM;
      OP_SUB, OP_SLT: begin
        c.b_inv = 1'b1;
        c.cin   = 1'b1;
        c.sel   = SEL_SUM;
      end
      // NOR as AND of both inverted operands
      OP_NOR: begin
        c.a_inv = 1'b1;
        c.b_inv = 1'b1;
        c.sel   = SEL_AND;
      end
      default: c.sel = SEL_ZERO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice: AND/OR/ripple-sum with optional operand inversion.
module alu_slice
  import serial_alu_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             a_inv,
  input  logic             b_inv,
  input  logic             cin,
  input  logic [1:0]       sel,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             msb_cin
);

  logic [SLICE-1:0] aa;
  logic [SLICE-1:0] bb;
  logic [SLICE-1:0] sum;
  logic [SLICE:0]   c;

  always_comb begin
    aa   = a ^ {SLICE{a_inv}};
    bb   = b ^ {SLICE{b_inv}};
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = aa[i] ^ bb[i] ^ c[i];
      c[i + 1] = (aa[i] & bb[i]) | (c[i] & (aa[i] ^ bb[i]));
    end
  end

  always_comb begin
    res = '0;
    unique case (sel)
      SEL_AND:  res = aa & bb;
      SEL_OR:   res = aa | bb;
      SEL_SUM:  res = sum;
      SEL_ZERO: res = '0;
    endcase
  end

  assign cout    = c[SLICE];
  assign msb_cin = c[SLICE-1];

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle ALU processing WIDTH bits as WIDTH/SLICE LSB-first slices (requires WIDTH > SLICE).
// Define SERIAL_ALU_FLAGS_EN to drive the zero/overflow flags; otherwise they are tied low.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned K  = WIDTH / SLICE;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [3:0]       op_q;
  logic             a_inv_q, b_inv_q;
  logic [1:0]       sel_q;

  ctrl_t            acc_ctrl;
  logic             accept, last, run;
  logic [SLICE-1:0] slice_res;
  logic             slice_cout, slice_msb_cin;
  logic             ovf;
  logic [WIDTH-1:0] shifted, final_res;

  assign acc_ctrl = decode_op(ALU_control);
  assign run      = (state_q == RUN);
  assign accept   = start && !run;
  assign last     = (cnt_q == CW'(K - 1));

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a       (a_q[SLICE-1:0]),
    .b       (b_q[SLICE-1:0]),
    .a_inv   (a_inv_q),
    .b_inv   (b_inv_q),
    .cin     (carry_q),
    .sel     (sel_q),
    .res     (slice_res),
    .cout    (slice_cout),
    .msb_cin (slice_msb_cin)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only meaningful on the final slice, where the slice MSB is the word MSB
  always_comb begin
    ovf       = slice_msb_cin ^ slice_cout;
    shifted   = {slice_res, result_q[WIDTH-1:SLICE]};
    final_res = shifted;
    if (op_q == OP_SLT) begin
      final_res = {{(WIDTH-1){1'b0}}, slice_res[SLICE-1] ^ ovf};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      a_inv_q  <= 1'b0;
      b_inv_q  <= 1'b0;
      sel_q    <= SEL_ZERO;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= src1;
        b_q     <= src2;
        op_q    <= ALU_control;
        a_inv_q <= acc_ctrl.a_inv;
        b_inv_q <= acc_ctrl.b_inv;
        sel_q   <= acc_ctrl.sel;
        carry_q <= acc_ctrl.cin;
        cnt_q   <= '0;
      end else if (run) begin
        a_q      <= a_q >> SLICE;
        b_q      <= b_q >> SLICE;
        carry_q  <= slice_cout;
        cnt_q    <= cnt_q + CW'(1);
        result_q <= last ? final_res : shifted;
      end
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q, ovf_q;
  logic is_addsub;

  assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (run && last) begin
      zero_q <= (final_res == '0);
      ovf_q  <= is_addsub & ovf;
    end
  end

  assign zero     = zero_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

  assign busy   = run;
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed table, randomized ops vs reference model,
// and multi-cycle corner sequences (start while busy, back-to-back, reset mid-run).
module tb_serial_alu;

  localparam int W = 32;
  localparam int S = 4;
  localparam int K = W / S;
`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ALU_control = 4'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result;

  int total = 0;
  int pass_cnt = 0;

  serial_alu #(.WIDTH(W), .SLICE(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ALU_control (ALU_control),
    .src1        (src1),
    .src2        (src2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  // Reference behaviour from plain arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic o);
    o = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = a + b;
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        r = a - b;
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  // Drives a request now; the next rising edge must accept it. Returns edges until done.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    ALU_control = op;
    src1 = a;
    src2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy after accept"}, {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 4 * K) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic verify(input string tag, input int lat, input logic [31:0] er,
                        input logic ez, input logic eo);
    check({tag, " latency"}, lat, K);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " busy in done"}, {31'b0, busy}, 32'd0);
    check({tag, " result"}, result, er);
    check({tag, " zero"}, {31'b0, zero}, {31'b0, ez & FLAGS});
    check({tag, " overflow"}, {31'b0, overflow}, {31'b0, eo & FLAGS});
  endtask

  initial begin
    vec_t        vecs[11];
    logic [31:0] corners[4];
    logic [3:0]  ops[6];
    logic [31:0] er, ra, rb;
    logic        ez, eo;
    logic [3:0]  rop;
    int          lat;
    int          dones;

    vecs[0]  = '{4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};
    vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[3]  = '{4'b0111, 32'hFFFFFFFD, 32'd2,        32'd1,        1'b0, 1'b0};
    vecs[4]  = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[7]  = '{4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 32'hDEADBEEF, 32'h12345678, 32'd0,        1'b1, 1'b0};
    vecs[9]  = '{4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1};
    vecs[10] = '{4'b0110, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0};

    corners = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    ops     = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", {31'b0, zero}, 32'd0);
    check("reset overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; consecutive entries are accepted in each other's done cycle
    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, lat);
      verify($sformatf("vec%0d", i), lat, vecs[i].r, vecs[i].z, vecs[i].o);
    end
    @(posedge clk);
    #1;
    check("done is one pulse", {31'b0, done}, 32'd0);

    // Randomized operations against the model
    for (int i = 0; i < 60; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
      model(rop, ra, rb, er, ez, eo);
      do_op($sformatf("rnd%0d op%0h", i, rop), rop, ra, rb, lat);
      verify($sformatf("rnd%0d op%0h", i, rop), lat, er, ez, eo);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // start held high with changing operands throughout RUN: only one op
    @(negedge clk);
    ALU_control = 4'b0010;
    src1 = 32'd100;
    src2 = 32'd23;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < K; i++) begin
      #1;
      ALU_control = 4'b0110;
      src1 = $urandom();
      src2 = $urandom();
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("start while busy done count", dones, 1);
    check("start while busy result", result, 32'd123);
    check("start while busy idle after", {31'b0, busy}, 32'd0);

    // Reset in the middle of RUN (cnt = 3)
    do_op("pre-reset", 4'b0110, 32'd1, 32'd2, lat);
    verify("pre-reset", lat, 32'hFFFFFFFF, 1'b0, 1'b0);
    ALU_control = 4'b0010;
    src1 = 32'hFFFFFFFF;
    src2 = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid-run reset busy", {31'b0, busy}, 32'd0);
    check("mid-run reset done", {31'b0, done}, 32'd0);
    check("mid-run reset result", result, 32'd0);
    check("mid-run reset zero", {31'b0, zero}, 32'd0);
    check("mid-run reset overflow", {31'b0, overflow}, 32'd0);
    do_op("post-reset", 4'b0010, 32'h12345678, 32'h11111111, lat);
    verify("post-reset", lat, 32'h23456789, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
